led_breathe_driver: RTL and testbench

- Downstream output stage for the board LED path. Consumes the on/off blink level from the top-level blinker as an enable.
- While enabled, drives the physical LED with a PWM signal whose duty ramps up and down ("breathing").
- Fully synchronous to the board oscillator. Also exports the current duty and a peak marker for debug or chaining.

---
 rtl/led_pkg.sv | 16 +
 rtl/tick_prescaler.sv | 39 +++
 rtl/led_breathe_driver.sv | 144 ++++++++++++++
 tb/tb_led_breathe_driver.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED breathe path.
// Holds the breathe FSM state encoding and the default timing constants used by
// the driver and its testbench.
package led_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRampUp   = 2'd1,
    StRampDown = 2'd2
  } led_state_e;

  localparam int unsigned LedPrescaleDefault    = 1000;
  localparam int unsigned LedPwmBitsDefault     = 8;
  localparam int unsigned LedHoldPeriodsDefault = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running tick divider.
// Emits a one-cycle tick every PRESCALE cycles of OSC while clr is low; clr
// holds the count at zero and suppresses the tick.
// Ports:
//   OSC   - clock
//   RST_N - asynchronous active-low reset
//   clr   - synchronous clear / hold-off
//   tick  - high in the cycle where the count equals PRESCALE-1
module tick_prescaler #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic OSC,
  input  logic RST_N,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = !clr && (cnt_q == CntMax);
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge OSC or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_breathe_driver.sv
// LED breathing PWM driver.
// While EN is high the duty ramps 0 -> max -> 0 repeatedly, one step every
// HOLD_PERIODS PWM periods; duty changes only on a period boundary. EN low
// returns everything to idle on the next edge.
// Optional build macro LED_BREATHE_GAMMA_EN: compare against (DUTY*DUTY)>>PWM_BITS
// instead of DUTY for a perceptually smoother ramp.
// Ports:
//   OSC     - board clock
//   RST_N   - asynchronous active-low reset
//   EN      - breathe enable (upstream blink level)
//   LED_OUT - registered PWM drive
//   DUTY    - current duty register
//   PEAK    - one-cycle pulse when DUTY reaches its maximum
module led_breathe_driver
  import led_pkg::*;
#(
  parameter int unsigned PRESCALE     = LedPrescaleDefault,
  parameter int unsigned PWM_BITS     = LedPwmBitsDefault,
  parameter int unsigned HOLD_PERIODS = LedHoldPeriodsDefault
) (
  input  logic                OSC,
  input  logic                RST_N,
  input  logic                EN,
  output logic                LED_OUT,
  output logic [PWM_BITS-1:0] DUTY,
  output logic                PEAK
);

  localparam int unsigned HoldW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [HoldW-1:0]    HoldMax      = HoldW'(HOLD_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] DutyOne      = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] DutyBelowMax = ~DutyOne;

  led_state_e          state_q, state_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                led_q, led_d;
  logic                peak_q, peak_d;

  logic                tick;
  logic                clr;
  logic                period_end;
  logic                step;
  logic [PWM_BITS-1:0] duty_eff;

  // The prescaler runs only in a ramp state with EN still high; entering a ramp
  // from idle therefore starts it from zero on the following cycle.
  assign clr = (state_q == StIdle) || !EN;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .OSC  (OSC),
    .RST_N(RST_N),
    .clr  (clr),
    .tick (tick)
  );

  assign period_end = tick && (pwm_q == '1);
  assign step       = period_end && (hold_q == HoldMax);

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS-1:0] duty_sq;
  assign duty_sq  = {{PWM_BITS{1'b0}}, duty_q} * {{PWM_BITS{1'b0}}, duty_q};
  assign duty_eff = duty_sq[2*PWM_BITS-1 -: PWM_BITS];
`else
  assign duty_eff = duty_q;
`endif

  always_comb begin
    state_d = state_q;
    pwm_d   = pwm_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    led_d   = 1'b0;
    peak_d  = 1'b0;

    if (!EN) begin
      state_d = StIdle;
      pwm_d   = '0;
      hold_d  = '0;
      duty_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StRampUp;
        end
        StRampUp, StRampDown: begin
          led_d = (pwm_q < duty_eff);
          if (tick) begin
            pwm_d = pwm_q + 1'b1;
          end
          if (period_end) begin
            hold_d = (hold_q == HoldMax) ? '0 : hold_q + 1'b1;
          end
          if (step) begin
            if (state_q == StRampUp) begin
              duty_d = duty_q + 1'b1;
              if (duty_q == DutyBelowMax) begin
                state_d = StRampDown;
                peak_d  = 1'b1;
              end
            end else begin
              duty_d = duty_q - 1'b1;
              if (duty_q == DutyOne) begin
                state_d = StRampUp;
              end
            end
          end
        end
        default: begin
          state_d = StIdle;
          pwm_d   = '0;
          hold_d  = '0;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge OSC or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      pwm_q   <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      led_q   <= 1'b0;
      peak_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pwm_q   <= pwm_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
      peak_q  <= peak_d;
    end
  end

  assign LED_OUT = led_q;
  assign DUTY    = duty_q;
  assign PEAK    = peak_q;

endmodule

// File: tb/tb_led_breathe_driver.sv
// Testbench for led_breathe_driver (PRESCALE=2, PWM_BITS=3, HOLD_PERIODS=1,
// PWM period 16 OSC cycles). Stimulus pushes one expected record per duty step;
// the monitor pops a record each time DUTY changes and checks the new duty,
// PEAK, cycles since the previous step and LED-high cycles of the period just
// finished.
module tb_led_breathe_driver;
  import led_pkg::*;

  localparam int unsigned TbPrescale = 2;
  localparam int unsigned TbPwmBits  = 3;
  localparam int unsigned TbHold     = 1;

  logic                 OSC = 1'b0;
  logic                 RST_N;
  logic                 EN;
  logic                 LED_OUT;
  logic [TbPwmBits-1:0] DUTY;
  logic                 PEAK;

  always #5 OSC = ~OSC;

  led_breathe_driver #(
    .PRESCALE    (TbPrescale),
    .PWM_BITS    (TbPwmBits),
    .HOLD_PERIODS(TbHold)
  ) dut (
    .OSC    (OSC),
    .RST_N  (RST_N),
    .EN     (EN),
    .LED_OUT(LED_OUT),
    .DUTY   (DUTY),
    .PEAK   (PEAK)
  );

  typedef struct {
    int duty;
    int peak;
    int interval;
    int led_cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t e_mon;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b0;
  int   cnt         = 0;
  int   led_cnt     = 0;
  int   extra_peak  = 0;
  int   cyc         = 0;
  int   last_peak   = -1;
  logic [TbPwmBits-1:0] duty_prev = '0;

  // Ramp sequence from 0: up to 7, down to 0, up to 7 again, then down to 5.
  localparam int SeqB[23] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0,
                              1, 2, 3, 4, 5, 6, 7, 6, 5};

  // LED-high OSC cycles in one 16-cycle period at duty d (2 cycles per tick).
  function automatic int expected_led(input int d);
`ifdef LED_BREATHE_GAMMA_EN
    return 2 * ((d * d) >> 3);
`else
    return 2 * d;
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int duty, input int interval, input int prev_duty);
    exp_t e;
    e.duty     = duty;
    e.peak     = (duty == 7) ? 1 : 0;
    e.interval = interval;
    e.led_cnt  = expected_led(prev_duty);
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while (sb_q.size() != 0 && i < budget) begin
      @(posedge OSC);
      i++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge OSC) begin
    cyc++;
    if (!mon_en) begin
      cnt        = 0;
      led_cnt    = 0;
      extra_peak = 0;
      last_peak  = -1;
      duty_prev  = DUTY;
    end else begin
      cnt++;
      if (LED_OUT) led_cnt++;
      if (DUTY != duty_prev) begin
        if (sb_q.size() == 0) begin
          check("unexpected_duty_change", int'(DUTY), int'(duty_prev));
        end else begin
          e_mon = sb_q.pop_front();
          check("step_duty", int'(DUTY), e_mon.duty);
          check("step_peak", int'(PEAK), e_mon.peak);
          check("step_interval", cnt, e_mon.interval);
          check("period_led_high", led_cnt, e_mon.led_cnt);
          check("stray_peak", extra_peak, 0);
          if (PEAK) begin
            if (last_peak >= 0) check("peak_spacing", cyc - last_peak, 224);
            last_peak = cyc;
          end
        end
        cnt        = 0;
        led_cnt    = 0;
        extra_peak = 0;
        duty_prev  = DUTY;
      end else if (PEAK) begin
        extra_peak++;
      end
    end
  end

  initial begin
    int prev;
    RST_N = 1'b0;
    EN    = 1'b0;
    #12;
    check("reset_led", int'(LED_OUT), 0);
    check("reset_duty", int'(DUTY), 0);
    check("reset_peak", int'(PEAK), 0);
    @(posedge OSC); #2;
    RST_N = 1'b1;

    // Ramp up, turnaround, second peak, stop at duty 5.
    @(posedge OSC); #2;
    prev = 0;
    for (int i = 0; i < 23; i++) begin
      push(SeqB[i], (i == 0) ? 18 : 16, prev);
      prev = SeqB[i];
    end
    mon_en = 1'b1;
    EN     = 1'b1;
    wait_drain(600);
    check("duty_before_reset", int'(DUTY), 5);

    // Asynchronous reset mid-ramp, between clock edges.
    mon_en = 1'b0;
    @(posedge OSC); #3;
    RST_N = 1'b0;
    #1;
    check("async_reset_led", int'(LED_OUT), 0);
    check("async_reset_duty", int'(DUTY), 0);
    check("async_reset_peak", int'(PEAK), 0);
    EN = 1'b0;
    #3;
    RST_N = 1'b1;
    repeat (3) @(posedge OSC);
    #1;
    check("idle_duty", int'(DUTY), 0);

    // Restart from 0 after reset, ramp to 4, then drop EN mid-period.
    @(posedge OSC); #2;
    prev = 0;
    for (int d = 1; d <= 4; d++) begin
      push(d, (d == 1) ? 18 : 16, prev);
      prev = d;
    end
    mon_en = 1'b1;
    EN     = 1'b1;
    wait_drain(200);
    repeat (2) @(posedge OSC);
    #1;
    check("led_mid_period_duty4", int'(LED_OUT), 1);
    #1;
    EN     = 1'b0;
    mon_en = 1'b0;
    @(posedge OSC); #1;
    check("en_drop_duty", int'(DUTY), 0);
    check("en_drop_led", int'(LED_OUT), 0);
    check("en_drop_peak", int'(PEAK), 0);
    repeat (4) @(posedge OSC);
    #1;
    check("en_low_led", int'(LED_OUT), 0);
    check("en_low_duty", int'(DUTY), 0);

    // Reassert: full first period again.
    @(posedge OSC); #2;
    push(1, 18, 0);
    push(2, 16, 1);
    mon_en = 1'b1;
    EN     = 1'b1;
    wait_drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
